// File: rtl/udp_rx_buffer.sv
// Receive-side payload buffer behind the UDP decoder: packets land tentatively, commit on a good fin, replay over valid/ready.
// Optional destination-port filtering is enabled by defining UDP_RX_PORT_FILTER_EN.
module udp_rx_buffer #(
   parameter int DEPTH      = 64,
   parameter int DESC_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_udp_out,
   input  logic        wr_en_udp,
   input  logic        ok_udp,
   input  logic        fin_udp,
   input  logic [15:0] len_udp_data,
   input  logic [15:0] src_port_udp,
   input  logic [15:0] dest_port_udp,
`ifdef UDP_RX_PORT_FILTER_EN
   input  logic [15:0] listen_port,
`endif
   output logic        pkt_valid,
   output logic [15:0] pkt_len,
   output logic [15:0] pkt_src_port,
   output logic [15:0] pkt_dest_port,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_last,
   input  logic        rd_ready,
   output logic [15:0] drop_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int DIW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
   localparam int DCW = $clog2(DESC_DEPTH) + 1;

   typedef struct packed {
      logic [15:0] len;
      logic [15:0] src;
      logic [15:0] dest;
      logic [15:0] words;
   } desc_t;

   typedef enum logic {IDLE, RECV} wr_state_t;
   typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

   logic [31:0]    mem [DEPTH];
   desc_t          desc_mem [DESC_DEPTH];

   logic [PW-1:0]  wr_commit, wr_tent, rd_ptr;
   logic [PW-1:0]  occupancy, wr_tent_next;
   logic           full;
   logic [15:0]    word_cnt, word_cnt_now, exp_words;
   logic           overflow, overflow_now;
   logic           word_write;
   logic           filtered, bad_pkt, do_commit, do_count;

   logic [DIW-1:0] desc_head, desc_tail;
   logic [DCW-1:0] desc_cnt;
   logic           desc_full, desc_pop;
   desc_t          head;

   wr_state_t      wr_state;
   rd_state_t      rd_state;
   logic [15:0]    beat_idx;
   logic           rd_fire, last_beat;

   function automatic logic [DIW-1:0] desc_inc(input logic [DIW-1:0] idx);
      return (idx == DIW'(DESC_DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   // Occupancy counts tentative words too, so an uncommitted packet can never overwrite unread data.
   assign occupancy    = wr_tent - rd_ptr;
   assign full         = (occupancy == PW'(DEPTH));
   assign word_write   = wr_en_udp && !full;
   assign wr_tent_next = wr_tent + PW'(word_write);
   assign word_cnt_now = word_cnt + 16'(word_write);
   assign overflow_now = overflow | (wr_en_udp & full);
   assign exp_words    = 16'((17'(len_udp_data) + 17'd3) >> 2);
   assign desc_full    = (desc_cnt == DCW'(DESC_DEPTH));

`ifdef UDP_RX_PORT_FILTER_EN
   assign filtered = (dest_port_udp != listen_port);
`else
   assign filtered = 1'b0;
`endif

   assign bad_pkt   = !ok_udp || overflow_now || (word_cnt_now != exp_words) || desc_full;
   assign do_commit = fin_udp && !filtered && !bad_pkt && (len_udp_data != 16'd0);
   assign do_count  = fin_udp && !filtered && bad_pkt;

   assign head          = desc_mem[desc_head];
   assign pkt_valid     = (desc_cnt != '0);
   assign pkt_len       = pkt_valid ? head.len  : 16'd0;
   assign pkt_src_port  = pkt_valid ? head.src  : 16'd0;
   assign pkt_dest_port = pkt_valid ? head.dest : 16'd0;
   assign rd_data       = pkt_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;
   assign last_beat     = (beat_idx == head.words - 16'd1);
   assign rd_last       = rd_valid && last_beat;
   assign rd_fire       = rd_valid && rd_ready;
   assign desc_pop      = rd_fire && last_beat;

   always_ff @(posedge clk) begin
      if (word_write)
         mem[wr_tent[AW-1:0]] <= data_udp_out;
      if (do_commit)
         desc_mem[desc_tail] <= '{len: len_udp_data, src: src_port_udp,
                                  dest: dest_port_udp, words: word_cnt_now};
   end

   // Write side: a fin either publishes wr_tent as the new commit point or rewinds to the last one.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state  <= IDLE;
         wr_tent   <= '0;
         wr_commit <= '0;
         word_cnt  <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         case (wr_state)
            IDLE:    if (wr_en_udp && !fin_udp) wr_state <= RECV;
            RECV:    if (fin_udp) wr_state <= IDLE;
            default: wr_state <= IDLE;
         endcase
         if (fin_udp) begin
            word_cnt <= '0;
            overflow <= 1'b0;
            if (do_commit) begin
               wr_tent   <= wr_tent_next;
               wr_commit <= wr_tent_next;
            end else begin
               wr_tent <= wr_commit;
            end
            if (do_count && drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end else begin
            wr_tent  <= wr_tent_next;
            word_cnt <= word_cnt_now;
            overflow <= overflow_now;
         end
      end
   end

   // Read side and descriptor FIFO; push and pop on the same edge cancel in the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         desc_head <= '0;
         desc_tail <= '0;
         desc_cnt  <= '0;
         rd_ptr    <= '0;
         beat_idx  <= '0;
         rd_state  <= R_IDLE;
         rd_valid  <= 1'b0;
      end else begin
         if (do_commit)
            desc_tail <= desc_inc(desc_tail);
         if (desc_pop)
            desc_head <= desc_inc(desc_head);
         desc_cnt <= desc_cnt + DCW'(do_commit) - DCW'(desc_pop);
         case (rd_state)
            R_IDLE: begin
               if (pkt_valid) begin
                  rd_state <= R_STREAM;
                  rd_valid <= 1'b1;
               end
            end
            R_STREAM: begin
               if (rd_fire) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (last_beat) begin
                     beat_idx <= '0;
                     rd_state <= R_IDLE;
                     rd_valid <= 1'b0;
                  end else begin
                     beat_idx <= beat_idx + 16'd1;
                  end
               end
            end
            default: begin
               rd_state <= R_IDLE;
               rd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Self-checking bench for udp_rx_buffer: directed scenarios plus randomized packets against a packet-level queue model.
// Builds with or without UDP_RX_PORT_FILTER_EN.
module tb_udp_rx_buffer;

   localparam int DEPTH      = 16;
   localparam int DESC_DEPTH = 4;
   localparam int WAIT_LIMIT = 1000;
   localparam logic [15:0] LISTEN = 16'h2694;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_udp_out = '0;
   logic        wr_en_udp = 1'b0;
   logic        ok_udp = 1'b0;
   logic        fin_udp = 1'b0;
   logic [15:0] len_udp_data = '0;
   logic [15:0] src_port_udp = '0;
   logic [15:0] dest_port_udp = '0;
   logic        rd_ready = 1'b0;
   logic        pkt_valid, rd_valid, rd_last;
   logic [15:0] pkt_len, pkt_src_port, pkt_dest_port, drop_cnt;
   logic [31:0] rd_data;
`ifdef UDP_RX_PORT_FILTER_EN
   logic [15:0] listen_port = LISTEN;
`endif

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [15:0] len;
      logic [15:0] src;
      logic [15:0] dest;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] pay_q[$];
   int          pkts_q = 0;
   int          exp_drops = 0;
   int          checks = 0;
   int          passes = 0;
   int          rd_mode = 0;

   always #5 clk = ~clk;

   udp_rx_buffer #(.DEPTH(DEPTH), .DESC_DEPTH(DESC_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .data_udp_out(data_udp_out), .wr_en_udp(wr_en_udp), .ok_udp(ok_udp), .fin_udp(fin_udp),
      .len_udp_data(len_udp_data), .src_port_udp(src_port_udp), .dest_port_udp(dest_port_udp),
`ifdef UDP_RX_PORT_FILTER_EN
      .listen_port(listen_port),
`endif
      .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_src_port(pkt_src_port),
      .pkt_dest_port(pkt_dest_port), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_last(rd_last), .rd_ready(rd_ready), .drop_cnt(drop_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   // One clock: inputs change #1 after the rising edge, rd_ready follows the current mode.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      case (rd_mode)
         0:       rd_ready = 1'b0;
         1:       rd_ready = 1'b1;
         2:       rd_ready = ~rd_ready;
         default: rd_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Sends pay_q as one packet; the model predicts commit, counted drop or silent drop from the packet rules.
   task automatic sendPacket(input int len, input int nwords, input bit ok,
                             input logic [15:0] src, input logic [15:0] dest, input bit together);
      int    free_words;
      int    expw;
      int    ncycles;
      bit    filtered;
      bit    bad;
      beat_t b;
      free_words = DEPTH - exp_q.size();
      expw       = (len + 3) / 4;
      ncycles    = (together && nwords > 0) ? nwords : nwords + 1;
      filtered   = 1'b0;
`ifdef UDP_RX_PORT_FILTER_EN
      filtered   = (dest != LISTEN);
`endif
      for (int c = 0; c < ncycles; c++) begin
         wr_en_udp    = (c < nwords);
         data_udp_out = (c < nwords) ? pay_q[c] : 32'd0;
         fin_udp      = (c == ncycles - 1);
         if (fin_udp) begin
            ok_udp        = ok;
            len_udp_data  = 16'(len);
            src_port_udp  = src;
            dest_port_udp = dest;
            bad = !ok || (nwords > free_words) || (nwords != expw) || (pkts_q >= DESC_DEPTH);
            if (!filtered && bad && exp_drops < 65535)
               exp_drops++;
            if (!filtered && !bad && len != 0) begin
               for (int i = 0; i < nwords; i++) begin
                  b.data = pay_q[i];
                  b.last = (i == nwords - 1);
                  b.len  = 16'(len);
                  b.src  = src;
                  b.dest = dest;
                  exp_q.push_back(b);
               end
               pkts_q++;
            end
         end
         applyStimulus();
      end
      wr_en_udp = 1'b0;
      fin_udp   = 1'b0;
      ok_udp    = 1'b0;
      checkOutput("drop_cnt_after_fin", 32'(drop_cnt), 32'(exp_drops));
   endtask

   task automatic fillRandom(input int n);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back($urandom());
   endtask

   task automatic waitRoom(input int n);
      int guard = 0;
      while ((exp_q.size() + n > DEPTH || pkts_q >= DESC_DEPTH) && guard < WAIT_LIMIT) begin
         applyStimulus();
         guard++;
      end
      if (guard == WAIT_LIMIT) checkOutput("room_timeout", 32'(guard), 32'(WAIT_LIMIT - 1));
   endtask

   task automatic waitDrain();
      int guard = 0;
      rd_mode = 1;
      while (exp_q.size() != 0 && guard < WAIT_LIMIT) begin
         applyStimulus();
         guard++;
      end
      checkOutput("drain_words_left", 32'(exp_q.size()), 32'd0);
      checkOutput("drain_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      checkOutput("drain_rd_valid", {31'd0, rd_valid}, 32'd0);
   endtask

   // Scoreboard: every accepted beat must match the next expected word and its packet descriptor.
   always @(negedge clk) begin
      if (!reset && rd_valid === 1'b1 && rd_ready) begin
         checkOutput("beat_pending", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            beat_t b;
            b = exp_q.pop_front();
            checkOutput("rd_data", rd_data, b.data);
            checkOutput("rd_last", {31'd0, rd_last}, {31'd0, b.last});
            checkOutput("beat_pkt_valid", {31'd0, pkt_valid}, 32'd1);
            checkOutput("pkt_len", 32'(pkt_len), 32'(b.len));
            checkOutput("pkt_src_port", 32'(pkt_src_port), 32'(b.src));
            checkOutput("pkt_dest_port", 32'(pkt_dest_port), 32'(b.dest));
            if (b.last) pkts_q--;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int nw, len, kind, gaps;
      bit ok;
      logic [15:0] dest;

      applyStimulus();
      applyStimulus();
      checkOutput("reset_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      checkOutput("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      checkOutput("reset_rd_last", {31'd0, rd_last}, 32'd0);
      checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("reset_rd_data", rd_data, 32'd0);
      checkOutput("reset_pkt_len", 32'(pkt_len), 32'd0);
      checkOutput("reset_src", 32'(pkt_src_port), 32'd0);
      checkOutput("reset_dest", 32'(pkt_dest_port), 32'd0);
      reset = 1'b0;
      applyStimulus();

      $display("[TB] Hello World packet");
      rd_mode = 1;
      pay_q.delete();
      pay_q.push_back(32'h48656c6c);
      pay_q.push_back(32'h6f20576f);
      pay_q.push_back(32'h726c6400);
      sendPacket(11, 3, 1'b1, 16'ha08f, 16'h2694, 1'b0);
      checkOutput("hello_pkt_valid", {31'd0, pkt_valid}, 32'd1);
      checkOutput("hello_pkt_len", 32'(pkt_len), 32'd11);
      checkOutput("hello_src", 32'(pkt_src_port), 32'h0000a08f);
      checkOutput("hello_dest", 32'(pkt_dest_port), 32'h00002694);
      waitDrain();
      checkOutput("hello_drop_cnt", 32'(drop_cnt), 32'd0);

      $display("[TB] bad checksum then good packet");
      sendPacket(11, 3, 1'b0, 16'ha08f, 16'h2694, 1'b1);
      checkOutput("badck_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      checkOutput("badck_drop_cnt", 32'(drop_cnt), 32'd1);
      fillRandom(3);
      sendPacket(12, 3, 1'b1, 16'h1111, 16'h2694, 1'b1);
      waitDrain();

      $display("[TB] zero-length packet");
      sendPacket(0, 0, 1'b1, 16'h2222, 16'h2694, 1'b0);
      checkOutput("zero_len_pkt_valid", {31'd0, pkt_valid}, 32'd0);

      $display("[TB] overflow and length mismatch");
      rd_mode = 0;
      fillRandom(DEPTH + 2);
      sendPacket(4 * (DEPTH + 2), DEPTH + 2, 1'b1, 16'h3333, 16'h2694, 1'b0);
      checkOutput("ovf_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      fillRandom(2);
      sendPacket(8, 2, 1'b1, 16'h4444, 16'h2694, 1'b1);
      checkOutput("post_ovf_pkt_valid", {31'd0, pkt_valid}, 32'd1);
      fillRandom(2);
      sendPacket(11, 2, 1'b1, 16'h5555, 16'h2694, 1'b0);
      waitDrain();

      $display("[TB] descriptor FIFO full");
      rd_mode = 0;
      for (int p = 0; p < DESC_DEPTH + 1; p++) begin
         fillRandom(1);
         sendPacket(4, 1, 1'b1, 16'(p), 16'h2694, 1'b0);
      end
      waitDrain();

      $display("[TB] back-to-back 3/1/5 word packets with toggling ready");
      rd_mode = 2;
      fillRandom(3);
      sendPacket(10, 3, 1'b1, 16'h0a01, 16'h2694, 1'b1);
      fillRandom(1);
      sendPacket(4, 1, 1'b1, 16'h0a02, 16'h2694, 1'b1);
      fillRandom(5);
      sendPacket(17, 5, 1'b1, 16'h0a03, 16'h2694, 1'b1);
      waitDrain();

      $display("[TB] reset mid-packet and mid-read");
      rd_mode = 0;
      fillRandom(5);
      sendPacket(20, 5, 1'b0, 16'h0b00, 16'h2694, 1'b0);
      fillRandom(5);
      sendPacket(20, 5, 1'b1, 16'h0b01, 16'h2694, 1'b0);
      rd_mode = 1;
      applyStimulus();
      checkOutput("pre_reset_rd_valid", {31'd0, rd_valid}, 32'd1);
      wr_en_udp    = 1'b1;
      data_udp_out = $urandom();
      applyStimulus();
      data_udp_out = $urandom();
      reset        = 1'b1;
      exp_q.delete();
      pkts_q    = 0;
      exp_drops = 0;
      applyStimulus();
      checkOutput("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("rst_rd_data", rd_data, 32'd0);
      reset     = 1'b0;
      wr_en_udp = 1'b0;
      applyStimulus();
      fillRandom(2);
      sendPacket(7, 2, 1'b1, 16'h0c00, 16'h2694, 1'b1);
      waitDrain();

      $display("[TB] randomized packets");
      for (int n = 0; n < 40; n++) begin
         rd_mode = 2 + $urandom_range(0, 1);
         kind    = $urandom_range(0, 9);
         nw      = $urandom_range(1, 6);
         len     = 4 * nw - $urandom_range(0, 3);
         if (kind == 0) len = 4 * nw + $urandom_range(1, 4);
         if (kind == 1) begin
            nw  = 0;
            len = 0;
         end
         ok   = ($urandom_range(0, 7) != 0);
         dest = $urandom_range(0, 1) ? LISTEN : 16'($urandom_range(0, 16'hffff));
         fillRandom(nw);
         waitRoom(nw);
         sendPacket(len, nw, ok, 16'($urandom_range(0, 16'hffff)), dest, 1'($urandom_range(0, 1)));
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) applyStimulus();
      end
      waitDrain();
      checkOutput("final_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
